// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared constants and types for the data-memory responder and
//               its lane-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // RV32 data path width
    localparam int c_XLEN = 32;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] c_F3_B  = 3'd0;
    localparam logic [2:0] c_F3_H  = 3'd1;
    localparam logic [2:0] c_F3_W  = 3'd2;
    localparam logic [2:0] c_F3_BU = 3'd4;
    localparam logic [2:0] c_F3_HU = 3'd5;

    // Responder transaction states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational RV32I byte/halfword/word lane steering. Extracts
//               and extends load data from an array word, merges store data
//               into an array word, and flags misaligned or illegal accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic              is_write,
    input  logic [2:0]        funct3,
    input  logic [1:0]        byte_off,
    input  logic [c_XLEN-1:0] word,
    input  logic [c_XLEN-1:0] wdata,
    output logic [c_XLEN-1:0] load_data,
    output logic [c_XLEN-1:0] store_word,
    output logic              misalign,
    output logic              illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword out of the array word
    always_comb begin
        w_byte = word[{byte_off, 3'b000} +: 8];
        w_half = byte_off[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the load type
    always_comb begin
        load_data = '0;
        case (funct3)
            c_F3_B:  load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: load_data = {24'd0, w_byte};
            c_F3_H:  load_data = {{16{w_half[15]}}, w_half};
            c_F3_HU: load_data = {16'd0, w_half};
            c_F3_W:  load_data = word;
            default: load_data = '0;
        endcase
    end

    // Merge right-aligned store data into the addressed lane, keep the rest
    always_comb begin
        store_word = word;
        case (funct3)
            c_F3_B: store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            c_F3_H: begin
                if (byte_off[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            c_F3_W:  store_word = wdata;
            default: store_word = word;
        endcase
    end

    // Stores only have B/H/W; loads additionally have BU/HU
    always_comb begin
        illegal  = is_write ? (funct3 > c_F3_W)
                            : ((funct3 == 3'd3) || (funct3 >= 3'd6));
        misalign = (((funct3 == c_F3_H) || (funct3 == c_F3_HU)) && byte_off[0])
                 || ((funct3 == c_F3_W) && (byte_off != 2'b00));
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Responder end of the data-memory interface. Accepts one
//               load/store at a time, waits WAIT_CYCLES, accesses a word array
//               and returns data or an error on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int CHECK_ALIGN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [c_XLEN-1:0] req_addr,
    input  logic [c_XLEN-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [c_XLEN-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_LIMIT    = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [c_XLEN-1:0] r_mem [DEPTH_WORDS];

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_accept, w_do_access;

    logic              r_write;
    logic [c_XLEN-1:0] r_addr, r_wdata;
    logic [2:0]        r_funct3;

    logic              w_acc_write;
    logic [c_XLEN-1:0] w_acc_addr, w_acc_wdata;
    logic [2:0]        w_acc_funct3;

    logic              w_oor, w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_XLEN-1:0] w_rd_word, w_load_data, w_store_word;
    logic              w_misalign, w_illegal;

    logic [c_XLEN-1:0] r_rdata;
    logic              r_err;

    // Held low while reset is asserted so nothing is accepted during reset
    assign req_ready = (r_state == ST_IDLE) && rst;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Next-state, wait counter and access strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_do_access = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = c_CNT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_do_access = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request at accept so later input changes are ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'd0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    // With zero wait states the access happens on the accept edge itself,
    // so the live request inputs are used while still in IDLE
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_write  = req_write;
            w_acc_addr   = req_addr;
            w_acc_wdata  = req_wdata;
            w_acc_funct3 = req_funct3;
        end else begin
            w_acc_write  = r_write;
            w_acc_addr   = r_addr;
            w_acc_wdata  = r_wdata;
            w_acc_funct3 = r_funct3;
        end
    end

    // Range check, array read and error combination
    always_comb begin
        w_oor     = ({1'b0, w_acc_addr} >= c_LIMIT);
        w_idx     = w_oor ? '0 : w_acc_addr[c_IDX_W+1:2];
        w_rd_word = r_mem[w_idx];
        w_err     = w_oor || w_illegal || ((CHECK_ALIGN != 0) && w_misalign);
    end

    mem_lane_align u_lane_align (
        .is_write   (w_acc_write),
        .funct3     (w_acc_funct3),
        .byte_off   (w_acc_addr[1:0]),
        .word       (w_rd_word),
        .wdata      (w_acc_wdata),
        .load_data  (w_load_data),
        .store_word (w_store_word),
        .misalign   (w_misalign),
        .illegal    (w_illegal)
    );

    // Array write; contents survive reset and errored stores never commit
    always_ff @(posedge clk) begin
        if (rst && w_do_access && w_acc_write && !w_err) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    // Response payload: loaded on access, held through RESP, cleared on handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_do_access) begin
            r_err   <= w_err;
            r_rdata <= (w_err || w_acc_write) ? '0 : w_load_data;
        end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder against a byte-level
//               reference memory model; covers a WAIT_CYCLES=2 and a
//               WAIT_CYCLES=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req0_valid = 1'b0, req0_ready, req0_write = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic [2:0]  req0_funct3 = 3'd0;
    logic        rsp0_valid, rsp0_ready = 1'b0, rsp0_err;
    logic [31:0] rsp0_rdata;

    int total = 0;
    int bad   = 0;

    // Byte-addressed reference memory covering addresses 0..255
    logic [7:0] mb [0:255];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CHECK_ALIGN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .CHECK_ALIGN(1)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req0_valid), .req_ready(req0_ready), .req_write(req0_write),
        .req_addr(req0_addr), .req_wdata(req0_wdata), .req_funct3(req0_funct3),
        .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready),
        .rsp_rdata(rsp0_rdata), .rsp_err(rsp0_err)
    );

    // Reference: access size/sign from funct3, byte-wise little-endian memory
    function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] f, output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        logic [31:0] v;
        rd = '0; er = 1'b0; sgn = 1'b0; size = 0;
        case (f)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        if (w && f > 3'd2) size = 0;
        if (size == 0 || a >= 32'd4096 || (int'(a[1:0]) % size) != 0) begin
            er = 1'b1;
            return;
        end
        if (w) begin
            for (int i = 0; i < size; i++) mb[a[7:0] + 8'(i)] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(mb[a[7:0] + 8'(i)]) << (8*i));
            if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rd = v;
        end
    endfunction

    // Drive one request on the WAIT_CYCLES=2 instance and collect its response.
    // lat counts edges from the accept edge (inclusive) to rsp_valid visible.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, output logic [31:0] rd, output logic er,
                          output int lat, output int wt);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
        rsp_ready = 1'b1;
        wt = 0;
        while (!req_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL txn_timeout addr=%h rsp_valid=%b required 1", a, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    // Same as do_txn for the zero-wait instance
    task automatic do_txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f, output logic [31:0] rd, output logic er,
                           output int lat, output int wt);
        req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d; req0_funct3 = f;
        rsp0_ready = 1'b1;
        wt = 0;
        while (!req0_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_addr = $urandom; req0_wdata = $urandom;
        lat = 1;
        while (!rsp0_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp0_rdata; er = rsp0_err;
        total++;
        if (rsp0_valid !== 1'b1) begin
            bad++;
            $display("FAIL txn0_timeout addr=%h rsp_valid=%b required 1", a, rsp0_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, req0_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got ready=%b valid=%b err=%b ready0=%b required all 0",
                     req_ready, rsp_valid, rsp_err, req0_ready);
        end
        total++;
        if (rsp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_rdata got %h required 0", rsp_rdata);
        end
        req_valid = 1'b0; req0_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({req_ready, req0_ready, rsp_valid} !== 3'b110) begin
            bad++;
            $display("FAIL reset_release got ready=%b ready0=%b valid=%b required 1 1 0",
                     req_ready, req0_ready, rsp_valid);
        end
    endtask

    // Fill words 0..63 bytes of the array with random data
    task automatic test_init();
        logic [31:0] rd, erd, d;
        logic er, eer;
        int lat, wt;
        for (int i = 0; i < 64; i += 4) begin
            d = $urandom;
            model(1'b1, 32'(i), d, 3'd2, erd, eer);
            do_txn(1'b1, 32'(i), d, 3'd2, rd, er, lat, wt);
            total++;
            if ({er, rd} !== {eer, erd}) begin
                bad++;
                $display("FAIL init_sw addr=%0d got err=%b rdata=%h required err=%b rdata=%h",
                         i, er, rd, eer, erd);
            end
        end
    endtask

    task automatic test_plan_basic();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, wt;
        model(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, erd, eer);
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, er, lat, wt);
        total++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
            bad++;
            $display("FAIL sw_basic got lat=%0d err=%b rdata=%h required 3 0 0", lat, er, rd);
        end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat, wt);
        total++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL lw_basic got lat=%0d err=%b rdata=%h required 3 0 deadbeef", lat, er, rd);
        end
        model(1'b1, 32'h11, 32'h80, 3'd0, erd, eer);
        do_txn(1'b1, 32'h11, 32'h80, 3'd0, rd, er, lat, wt);
        do_txn(1'b0, 32'h11, 32'h0, 3'd0, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b0, 32'hFFFFFF80}) begin
            bad++;
            $display("FAIL lb_sign got err=%b rdata=%h required 0 ffffff80", er, rd);
        end
        do_txn(1'b0, 32'h11, 32'h0, 3'd4, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b0, 32'h00000080}) begin
            bad++;
            $display("FAIL lbu_zero got err=%b rdata=%h required 0 00000080", er, rd);
        end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b0, 32'hDEAD80EF}) begin
            bad++;
            $display("FAIL sb_merge got err=%b rdata=%h required 0 dead80ef", er, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, wt;
        do_txn(1'b0, 32'h13, 32'h0, 3'd1, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL lh_misalign got err=%b rdata=%h required 1 0", er, rd);
        end
        do_txn(1'b1, 32'h4000, 32'h55AA55AA, 3'd2, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL sw_range got err=%b rdata=%h required 1 0", er, rd);
        end
        do_txn(1'b1, 32'h10, 32'h11111111, 3'd3, rd, er, lat, wt);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL store_f3_illegal got err=%b required 1", er);
        end
        do_txn(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b0, 32'hDEAD80EF}) begin
            bad++;
            $display("FAIL err_nowrite got err=%b rdata=%h required 0 dead80ef", er, rd);
        end
        model(1'b0, 32'h10, 32'h0, 3'd6, erd, eer);
        do_txn(1'b0, 32'h10, 32'h0, 3'd6, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {eer, erd}) begin
            bad++;
            $display("FAIL load_f3_illegal got err=%b rdata=%h required %b %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, d;
        logic er, eer, w;
        logic [2:0] f;
        int lat, wt;
        for (int n = 0; n < 150; n++) begin
            w = 1'($urandom);
            f = 3'($urandom);
            d = $urandom;
            a = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 65535)))
                                            : 32'($urandom_range(0, 63));
            model(w, a, d, f, erd, eer);
            do_txn(w, a, d, f, rd, er, lat, wt);
            total++;
            if ({er, rd} !== {eer, erd} || lat !== 3) begin
                bad++;
                $display("FAIL random w=%b f3=%0d addr=%h got err=%b rdata=%h lat=%0d required err=%b rdata=%h lat=3",
                         w, f, a, er, rd, lat, eer, erd);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] erd, erd2;
        logic eer, eer2;
        int lat;
        model(1'b0, 32'h10, 32'h0, 3'd2, erd, eer);
        model(1'b0, 32'h14, 32'h0, 3'd2, erd2, eer2);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_addr = 32'h14;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, eer, erd}) begin
                bad++;
                $display("FAIL hold_resp cyc=%0d got valid=%b ready=%b err=%b rdata=%h required 1 0 %b %h",
                         i, rsp_valid, req_ready, rsp_err, rsp_rdata, eer, erd);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL resp_release got valid=%b ready=%b err=%b rdata=%h required 0 1 0 0",
                     rsp_valid, req_ready, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, eer2, erd2} || lat !== 3) begin
            bad++;
            $display("FAIL held_req got valid=%b err=%b rdata=%h lat=%0d required 1 %b %h 3",
                     rsp_valid, rsp_err, rsp_rdata, lat, eer2, erd2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, wt;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h12345678; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL reset_in_wait cyc=%0d got valid=%b ready=%b err=%b rdata=%h required all 0",
                         i, rsp_valid, req_ready, rsp_err, rsp_rdata);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        model(1'b0, 32'h20, 32'h0, 3'd2, erd, eer);
        do_txn(1'b0, 32'h20, 32'h0, 3'd2, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {eer, erd}) begin
            bad++;
            $display("FAIL abort_nowrite got err=%b rdata=%h required %b %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_reset_resp();
        logic [31:0] rd, erd, d;
        logic er, eer;
        int lat, wt;
        d = $urandom;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h24; req_wdata = d; req_funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL store_resp got valid=%b err=%b rdata=%h required 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_resp got valid=%b required 0", rsp_valid);
        end
        model(1'b1, 32'h24, d, 3'd2, erd, eer);
        do_txn(1'b0, 32'h24, 32'h0, 3'd2, rd, er, lat, wt);
        total++;
        if ({er, rd} !== {1'b0, d}) begin
            bad++;
            $display("FAIL committed_store got err=%b rdata=%h required 0 %h", er, rd, d);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        logic [31:0] dv [4];
        logic er;
        int lat, wt;
        for (int i = 0; i < 4; i++) begin
            dv[i] = $urandom;
            do_txn0(1'b1, 32'(4*i), dv[i], 3'd2, rd, er, lat, wt);
            total++;
            if (lat !== 1 || wt !== 0 || er !== 1'b0) begin
                bad++;
                $display("FAIL zw_sw idx=%0d got lat=%0d wait=%0d err=%b required 1 0 0", i, lat, wt, er);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_txn0(1'b0, 32'(4*i), 32'h0, 3'd2, rd, er, lat, wt);
            total++;
            if (lat !== 1 || wt !== 0 || {er, rd} !== {1'b0, dv[i]}) begin
                bad++;
                $display("FAIL zw_lw idx=%0d got lat=%0d wait=%0d err=%b rdata=%h required 1 0 0 %h",
                         i, lat, wt, er, rd, dv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_plan_basic();
        test_errors();
        test_random();
        test_backpressure();
        test_reset_wait();
        test_reset_resp();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface.
- Accepts one load/store request at a time from the pipeline's memory stage over a valid/ready handshake.
- Performs RV32I byte/halfword/word access with sign or zero extension against an internal word-organised array, after a configurable wait-state delay.
- Returns read data or an error flag on a separate valid/ready response channel. Only one transaction is outstanding at a time.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; addressable range is 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between request accept and response; legal range 0 to 15.
- CHECK_ALIGN, 1, when 1, misaligned halfword/word accesses return an error; when 0, low address bits are ignored.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_funct3  input  3  RV32I funct3 of the load/store.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load result, already extended; 0 for stores and for errors.
- rsp_err  output  1  access error (out of range, misaligned, or illegal funct3).

Behaviour:
- Reset (rst=0 at clk edge):
  - State goes to IDLE.
  - Outputs: req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready becomes 1 on the first cycle after reset is released.
  - Wait counter is cleared.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture write, addr, wdata, funct3. Load counter with WAIT_CYCLES-1 and go to WAIT; if WAIT_CYCLES=0, go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, perform the access and go to RESP.
  - Total latency from accept edge to rsp_valid=1 is WAIT_CYCLES+1 cycles.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready, go to IDLE, drop rsp_valid, and clear rsp_rdata/rsp_err to 0.
  - Minimum issue period is WAIT_CYCLES+2 cycles.
- Access rules:
  - Word index is addr[31:2], byte lane is addr[1:0].
  - Loads:
    - funct3 0 (LB) sign-extends, funct3 4 (LBU) zero-extends the selected byte.
    - funct3 1 (LH) and 5 (LHU) do the same for the halfword at lane addr[1].
    - funct3 2 (LW) returns the whole word.
  - Stores:
    - funct3 0 (SB) writes wdata[7:0] to the selected lane only.
    - funct3 1 (SH) writes wdata[15:0] to the selected halfword.
    - funct3 2 (SW) writes the whole word.
    - Unselected bytes are preserved.
  - The store commits on the same edge that enters RESP; a load issued afterwards sees the new data.
- Error conditions set rsp_err=1, perform no write, and return rsp_rdata=0:
  - addr >= 4*DEPTH_WORDS.
  - Illegal funct3: 3, 6 or 7 for loads; 3 and above for stores.
  - CHECK_ALIGN=1 and either a halfword access with addr[0]=1 or a word access with addr[1:0]!=0.
- Boundary cases:
  - req_valid held while busy: ignored until IDLE; the request is not lost and is accepted on the IDLE cycle.
  - Request inputs changing while busy have no effect, because they were captured at accept.
  - rsp_ready high before rsp_valid: no effect.
  - rsp_ready low: RESP holds indefinitely; no new request is accepted.
  - Reset in WAIT: transaction aborted, no write, no response.
  - Reset in RESP: store already committed; response discarded.
  - Counter is 4 bits wide; no wrap occurs within the legal WAIT_CYCLES range.

Decomposition:
- Shared package (extends the core's package):
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State encoding IDLE=0, WAIT=1, RESP=2.
  - RV32 data width of 32.
- Sub-module mem_lane_align (combinational):
  - Inputs: funct3, addr[1:0], array word, wdata.
  - Outputs: extended load data, merged store word, misalign/illegal flags.
  - Reused by the instruction-side responder.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10, WAIT_CYCLES=2 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
- SB 0x11 data 0x80, then LB 0x11 and LBU 0x11 -> word becomes 0xDEAD80EF; LB=0xFFFFFF80, LBU=0x00000080.
- LH 0x13 with CHECK_ALIGN=1 -> rsp_err=1, rdata=0; SW 0x4000 with DEPTH_WORDS=1024 -> rsp_err=1 and the array is unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid and rdata stay stable, req_ready=0; on rsp_ready=1, the next request is accepted the following cycle.
- WAIT_CYCLES=0, back-to-back LW with rsp_ready=1 -> accept every 2 cycles, latency 1.
- Assert rst=0 during WAIT of SW 0x20 data 0x12345678 -> no response; after reset, LW 0x20 returns the prior value; outputs are 0 during reset.
